// File: rtl/if_stage_mo_pkg.sv
// Shared definitions for the multi-outstanding fetch stage: entry layout and defaults.
package if_stage_mo_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h1C00_0000;

    // Buffer entry layout, MSB to LSB: {adef, pc, inst}.
    function automatic int unsigned entry_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int unsigned pc_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned adef_bit(input int unsigned addr_w, input int unsigned data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/if_stage_mo_fetch_ibuf.sv
// Synchronous FIFO with explicit pointer wrap; flush overrides push and pop.
module fetch_ibuf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;

    // Pop only when occupied; push into a full FIFO only alongside a pop.
    always_comb begin
        pop_en   = pop && (count_q != '0);
        push_en  = push && ((32'(count_q) < DEPTH) || pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        if (push_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign count = count_q;
    assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/if_stage_mo.sv
// Pipelined instruction fetch: several reads in flight, in-order responses, fetch buffer.
module if_stage_mo
    import if_stage_mo_pkg::*;
#(
    parameter int unsigned       ADDR_W          = DEF_ADDR_W,
    parameter int unsigned       DATA_W          = DEF_DATA_W,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter int unsigned       IBUF_DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    input  logic              inst_data_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              out_adef
);

    localparam int unsigned ENTRY_W  = entry_w(ADDR_W, DATA_W);
    localparam int unsigned PC_LSB   = pc_lsb(DATA_W);
    localparam int unsigned ADEF_BIT = adef_bit(ADDR_W, DATA_W);
    localparam int unsigned OW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW       = $clog2(IBUF_DEPTH + 1);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [OW-1:0]      outstanding_q, outstanding_d;
    logic [OW-1:0]      stale_q, stale_d;
    logic               halted_q, halted_d;
    logic [OW-1:0]      live;

    logic [CW-1:0]      ibuf_count;
    logic [ENTRY_W-1:0] ibuf_head;
    logic [ENTRY_W-1:0] ibuf_push_data;
    logic               ibuf_push, ibuf_pop;
    logic [OW-1:0]      pcq_count;
    logic [ADDR_W-1:0]  pcq_head;

    logic               req_fire, resp_keep, adef_fire, aligned;

    // Request, response-acceptance and ADEF-insertion decisions.
    always_comb begin
        live      = outstanding_q - stale_q;
        aligned   = (pc_q[1:0] == 2'b00);
        inst_req  = !reset && !redirect_valid && !halted_q && aligned
                    && (32'(outstanding_q) < MAX_OUTSTANDING)
                    && ((32'(live) + 32'(ibuf_count)) < IBUF_DEPTH);
        req_fire  = inst_req && inst_addr_ok;
        resp_keep = inst_data_ok && (stale_q == '0) && !redirect_valid;
        // Misaligned PC waits until every live response has landed so order is kept.
        adef_fire = !reset && !redirect_valid && !halted_q && !aligned
                    && (live == '0) && (32'(ibuf_count) < IBUF_DEPTH);
        out_valid = !reset && (ibuf_count != '0) && !redirect_valid;
        ibuf_pop  = out_valid && out_ready;
        ibuf_push = resp_keep || adef_fire;
        ibuf_push_data = adef_fire ? {1'b1, pc_q, {DATA_W{1'b0}}}
                                   : {1'b0, pcq_head, inst_rdata};
    end

    // Next-state for PC, in-flight counters and halt flag.
    always_comb begin
        pc_d          = pc_q;
        halted_d      = halted_q;
        stale_d       = stale_q;
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(inst_data_ok);
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
            // Everything still unanswered after this edge belongs to the old path.
            stale_d  = outstanding_q - OW'(inst_data_ok);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + ADDR_W'(4);
            end
            if (adef_fire) begin
                halted_d = 1'b1;
            end
            if (inst_data_ok && (stale_q != '0)) begin
                stale_d = stale_q - 1'b1;
            end
        end
    end

    // Fetch control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
            halted_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            halted_q      <= halted_d;
        end
    end

    // PCs of accepted requests, popped as responses return in order.
    fetch_ibuf #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (inst_data_ok),
        .flush     (1'b0),
        .count     (pcq_count),
        .head      (pcq_head)
    );

    fetch_ibuf #(
        .WIDTH (ENTRY_W),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .push      (ibuf_push),
        .push_data (ibuf_push_data),
        .pop       (ibuf_pop),
        .flush     (redirect_valid),
        .count     (ibuf_count),
        .head      (ibuf_head)
    );

    assign inst_addr = pc_q;
    assign out_pc    = ibuf_head[PC_LSB +: ADDR_W];
    assign out_inst  = ibuf_head[0 +: DATA_W];
    assign out_adef  = ibuf_head[ADEF_BIT];

    a_no_orphan_resp : assert property (@(posedge clk) disable iff (reset)
        inst_data_ok |-> (outstanding_q != '0));

    a_pcq_tracks : assert property (@(posedge clk) disable iff (reset)
        pcq_count == outstanding_q);

endmodule

// File: tb/tb_if_stage_mo.sv
// Randomised bench for if_stage_mo against a queue-based reference model.
module tb_if_stage_mo;

    localparam int          MAXO   = 2;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } pend_t;

    typedef struct packed {
        logic        adef;
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adef;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    bit          m_halted;
    pend_t       pend[$];
    ent_t        buff[$];
    logic [31:0] bus_q[$];

    if_stage_mo #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .MAX_OUTSTANDING (MAXO),
        .IBUF_DEPTH      (DEPTH),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_rdata     (inst_rdata),
        .inst_data_ok   (inst_data_ok),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_adef       (out_adef)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        m_pc     = RST_PC;
        m_halted = 1'b0;
        pend.delete();
        buff.delete();
        bus_q.delete();
    endtask

    // One bus/decode cycle: drive, compare against the model, advance both at the edge.
    task automatic step(input int p_ready, input int p_aok, input int p_dok, input int p_redir,
                        input bit frc, input logic [31:0] frc_pc);
        int          live;
        int          bsz;
        bit          rv, dok, acc, exp_req, exp_valid;
        logic [31:0] rpc, acc_addr;
        pend_t       p;
        @(negedge clk);
        reset = 1'b0;
        rv    = frc || (int'($urandom_range(99)) < p_redir);
        rpc   = 32'h1C00_0000 + ($urandom_range(0, 1023) << 2);
        if ($urandom_range(7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
        if (frc) rpc = frc_pc;
        dok = (bus_q.size() != 0) && (int'($urandom_range(99)) < p_dok);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = int'($urandom_range(99)) < p_ready;
        inst_addr_ok   = int'($urandom_range(99)) < p_aok;
        inst_data_ok   = dok;
        inst_rdata     = dok ? memval(bus_q[0]) : $urandom();
        #1;
        live = 0;
        foreach (pend[i]) if (!pend[i].stale) live++;
        bsz       = buff.size();
        exp_req   = !rv && !m_halted && (m_pc[1:0] == 2'b00) && (pend.size() < MAXO)
                    && (live + bsz < DEPTH);
        exp_valid = (bsz != 0) && !rv;
        check("inst_req", inst_req, exp_req);
        if (exp_req) check("inst_addr", inst_addr, m_pc);
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            check("out_pc", out_pc, buff[0].pc);
            check("out_inst", out_inst, buff[0].inst);
            check("out_adef", out_adef, buff[0].adef);
        end
        acc      = inst_req && inst_addr_ok;
        acc_addr = inst_addr;
        @(posedge clk);
        if (dok) void'(bus_q.pop_front());
        if (acc) bus_q.push_back(acc_addr);
        if (rv) begin
            m_pc     = rpc;
            m_halted = 1'b0;
            buff.delete();
            if (dok && pend.size() != 0) void'(pend.pop_front());
            foreach (pend[i]) pend[i].stale = 1'b1;
        end else begin
            if (exp_valid && out_ready) void'(buff.pop_front());
            if (dok && pend.size() != 0) begin
                p = pend.pop_front();
                if (!p.stale) buff.push_back('{adef: 1'b0, pc: p.pc, inst: memval(p.pc)});
            end
            if (!m_halted && m_pc[1:0] != 2'b00 && live == 0 && bsz < DEPTH) begin
                buff.push_back('{adef: 1'b1, pc: m_pc, inst: 32'h0});
                m_halted = 1'b1;
            end
            if (exp_req && inst_addr_ok) begin
                pend.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n, input int p_ready, input int p_aok, input int p_dok,
                       input int p_redir);
        for (int i = 0; i < n; i++) step(p_ready, p_aok, p_dok, p_redir, 1'b0, 32'h0);
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_inst_req", inst_req, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);

        // Streaming, then backpressure and release.
        run(30, 100, 100, 100, 0);
        run(10, 0, 100, 100, 0);
        run(15, 100, 100, 100, 0);

        // Redirect with two outstanding, responses withheld.
        run(3, 100, 100, 0, 0);
        step(100, 100, 0, 0, 1'b1, 32'h1C00_1000);
        run(20, 100, 100, 100, 0);

        // Redirect coincident with a response while two are outstanding.
        run(3, 100, 100, 0, 0);
        step(100, 100, 100, 0, 1'b1, 32'h1C00_1000);
        run(20, 100, 100, 100, 0);

        // Misaligned target halts fetch until the next redirect.
        step(100, 100, 100, 0, 1'b1, 32'h1C00_0002);
        run(15, 100, 100, 100, 0);
        step(100, 100, 100, 0, 1'b1, 32'h1C00_0100);
        run(15, 100, 100, 100, 0);

        // Random traffic.
        run(3000, 70, 70, 60, 4);

        // Reset in the middle of activity.
        run(4, 0, 100, 0, 0);
        run(2, 0, 100, 100, 0);
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        inst_data_ok   = 1'b0;
        inst_addr_ok   = 1'b0;
        #1;
        check("rst_mid_inst_req", inst_req, 1'b0);
        @(posedge clk);
        model_reset();
        run(15, 100, 100, 100, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage_mo.md
Name: if_stage_mo

Overview:
- Parametrised successor to the single-request fetch stage.
- Issues up to MAX_OUTSTANDING pipelined instruction-bus reads and pairs in-order responses with their PCs.
- Holds fetched instructions in an IBUF_DEPTH-entry buffer with a valid/ready handshake to decode.
- On redirect (branch, exception, ertn) it flushes the buffer and silently drops stale responses. Misaligned PCs produce an ADEF-flagged entry instead of a bus request.

Parameters:
- ADDR_W, 32, PC and bus address width
- DATA_W, 32, instruction width
- MAX_OUTSTANDING, 2, max accepted-but-unanswered requests (>=1)
- IBUF_DEPTH, 4, fetch buffer entries (>= MAX_OUTSTANDING)
- RESET_PC, 32'h1C000000, first fetch address after reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  redirect request from later stages; highest priority
- redirect_pc  in  ADDR_W  new fetch PC
- inst_req  out  1  bus request
- inst_addr  out  ADDR_W  request address (= pc)
- inst_addr_ok  in  1  request accepted this cycle
- inst_rdata  in  DATA_W  response data
- inst_data_ok  in  1  response valid; responses arrive in request order
- out_valid  out  1  decode entry available
- out_ready  in  1  decode accepts entry
- out_pc  out  ADDR_W  entry PC
- out_inst  out  DATA_W  entry instruction (0 when out_adef)
- out_adef  out  1  fetch-address-error flag

Behaviour:
- Reset values:
  - pc = RESET_PC.
  - outstanding = 0, stale = 0, buffer empty, halted = 0.
  - inst_req = 0, out_valid = 0.
  - The bus is reset together with this block.
- Counts:
  - outstanding = accepted requests not yet answered.
  - stale = the oldest of those whose data must be dropped; stale <= outstanding.
  - live = outstanding - stale.
  - count = buffer occupancy.
- inst_req is combinational; it is 1 only when all of the following hold:
  - !redirect_valid and !halted
  - pc[1:0] == 0
  - outstanding < MAX_OUTSTANDING
  - live + count < IBUF_DEPTH
- Request handshake and response ordering:
  - inst_req & inst_addr_ok: pc += 4, outstanding += 1, and pc is pushed into the MAX_OUTSTANDING-deep PC queue.
  - inst_data_ok: outstanding -= 1 and the PC queue pops.
  - If stale > 0: stale -= 1 and the data is dropped.
  - Otherwise {adef = 0, pc, rdata} is written to the buffer.
  - Space is always guaranteed; data_ok with outstanding == 0 is a bus protocol error (assertion).
- Misaligned PC (pc[1:0] != 0, not halted, no redirect):
  - Once live == 0 and count < IBUF_DEPTH, write {adef = 1, pc, 0} to the buffer and set halted = 1.
  - No further requests until redirect.
- Output:
  - out_valid = (count != 0) & !redirect_valid.
  - The head entry is driven on out_pc, out_inst and out_adef.
  - out_valid & out_ready pops the head.
  - Push and pop in the same cycle are legal at any occupancy, including full.
- Redirect (any cycle, takes effect at the clock edge):
  - pc = redirect_pc, halted = 0, buffer emptied.
  - stale = outstanding - inst_data_ok, i.e. every request still unanswered after this edge becomes stale.
  - No push or pop occurs in that cycle; inst_req is 0, so there is no new handshake.
  - The cycle after a redirect may issue to redirect_pc while stale responses are still draining.
- Back-to-back redirects: the later one wins and stale is recomputed the same way.
- Latency: redirect to first inst_req is 1 cycle. Response to out_valid is 1 cycle (registered buffer write).
- Widths:
  - outstanding and stale are $clog2(MAX_OUTSTANDING+1) bits.
  - count is $clog2(IBUF_DEPTH+1) bits.
  - Buffer pointers wrap modulo IBUF_DEPTH; non-power-of-two depths must wrap explicitly.
  - pc + 4 wraps modulo 2^ADDR_W.

Decomposition:
- Shared header if_defs:
  - entry field widths and offsets: ENTRY_W = 1 + ADDR_W + DATA_W, ordered {adef, pc, inst};
  - the ADEF flag position;
  - the RESET_PC default.
- One sub-module, fetch_ibuf: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/flush/count and a head output, where flush overrides push and pop.
- The PC queue reuses fetch_ibuf with DEPTH = MAX_OUTSTANDING and flush tied to 0.

Test Plan:
- Streaming: addr_ok always 1, data_ok 1 cycle after accept, out_ready = 1 → out_pc 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles; outstanding never exceeds 2.
- Backpressure: out_ready = 0 for 10 cycles → exactly 4 entries buffered; inst_req stays 0 while live + count == 4; the release drains entries in PC order with no loss or duplicate.
- Redirect with 2 outstanding: redirect_pc = 0x1C001000 → both late responses dropped; next out_pc = 0x1C001000; out_valid = 0 during the redirect cycle.
- Redirect coincident with data_ok while outstanding = 2 → stale = 1; that data is dropped and the next response belongs to 0x1C001000.
- Misaligned redirect_pc = 0x1C000002 → no inst_req; one entry {adef = 1, pc = 0x1C000002, inst = 0}; halted until redirect to 0x1C000100 resumes fetch.
- Reset asserted with 2 outstanding and 3 buffered → next cycle out_valid = 0, inst_req = 1 at 0x1C000000.
